// File: rtl/mmio_pkg.sv
// Shared types and helpers for the MMIO bus bridge.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [19:0] IO_PREFIX_DEF = 20'hFFFFF;

    // Index field is one bit wider than a bare slave number so out-of-range
    // indices (e.g. 5 with 4 slaves) are visible to the decoder as misses.
    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mmio_bus_if.sv
// CPU-side request/response channel of the MMIO bus bridge.
interface mmio_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic                resp_valid;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_err;
    logic                stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/mmio_decode.sv
// Combinational address decode: IO prefix match plus slave index range check.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int          N_SLV     = 4,
    parameter int          SEL_W     = 3,
    parameter logic [19:0] IO_PREFIX = IO_PREFIX_DEF
) (
    input  logic [19:0]      i_prefix,
    input  logic [SEL_W-1:0] i_idx,
    output logic             o_hit,
    output logic [SEL_W-1:0] o_idx
);
    localparam logic [SEL_W:0] NS = (SEL_W + 1)'(N_SLV);

    assign o_hit = (i_prefix == IO_PREFIX) && ({1'b0, i_idx} < NS);
    assign o_idx = i_idx;
endmodule

// File: rtl/mmio_bus.sv
// Single-outstanding MMIO bridge: decodes a CPU request onto one of N_SLV
// peripheral channels, waits for its ack or a timeout, returns one response.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          N_SLV     = 4,
    parameter int          SEL_LSB   = 4,
    parameter logic [19:0] IO_PREFIX = IO_PREFIX_DEF,
    parameter int          TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    mmio_bus_if.slave                 bus,
    output logic [N_SLV-1:0]          slv_sel,
    output logic                      slv_we,
    output logic [SEL_LSB-1:0]        slv_addr,
    output logic [DATA_W-1:0]         slv_wdata,
    output logic [DATA_W/8-1:0]       slv_wstrb,
    input  logic [N_SLV-1:0]          slv_ack,
    input  logic [N_SLV*DATA_W-1:0]   slv_rdata
);
    localparam int         SEL_W   = sel_w(N_SLV);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 2);

    state_e              r_state;
    logic [7:0]          r_cnt;
    logic                r_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [N_SLV-1:0]    r_sel;
    logic                r_we;
    logic [SEL_LSB-1:0]  r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;

    logic                w_hit;
    logic [SEL_W-1:0]    w_idx;
    logic                w_ack;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_unused_addr;

    mmio_decode #(
        .N_SLV    (N_SLV),
        .SEL_W    (SEL_W),
        .IO_PREFIX(IO_PREFIX)
    ) u_decode (
        .i_prefix(bus.req_addr[ADDR_W-1 -: 20]),
        .i_idx   (bus.req_addr[SEL_LSB +: SEL_W]),
        .o_hit   (w_hit),
        .o_idx   (w_idx)
    );

    assign w_unused_addr = ^bus.req_addr;

    // r_sel is one-hot, so masking replaces a variable-index mux and
    // automatically ignores acks from unselected slaves.
    assign w_ack = |(slv_ack & r_sel);

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_SLV; i++)
            if (r_sel[i]) w_rdata = w_rdata | slv_rdata[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr[SEL_LSB-1:0];
                        r_wdata <= bus.req_wdata;
                        r_wstrb <= bus.req_wstrb;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        if (w_hit) begin
                            r_sel   <= N_SLV'(1) << w_idx;
                            r_state <= ACCESS;
                        end else begin
                            r_rdata      <= '0;
                            r_err        <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (w_ack) begin
                        r_rdata      <= r_we ? '0 : w_rdata;
                        r_err        <= 1'b0;
                        r_sel        <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_cnt        <= r_cnt + 8'd1;
                        r_rdata      <= '0;
                        r_err        <= 1'b1;
                        r_sel        <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.stall      = (r_state != IDLE) || bus.req_valid;

    assign slv_sel   = r_sel;
    assign slv_we    = r_we;
    assign slv_addr  = r_addr;
    assign slv_wdata = r_wdata;
    assign slv_wstrb = r_wstrb;
endmodule
